cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 3, the number of functional-unit requesters (legal range 2..8).
REQ-002 SHALL have parameter PREG_W, default 8, the physical register index width (matches free_list_t).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush after a branch mispredict.
REQ-006 SHALL have port fu_valid  input  NUM_FU  per-FU writeback request.
REQ-007 SHALL have port fu_ready  output  NUM_FU  per-FU grant (combinational).
REQ-008 SHALL have port fu_preg  input  NUM_FU x PREG_W  destination physical register per FU.
REQ-009 SHALL have port fu_pkt  input  NUM_FU x physical_reg_packet  result value plus ROB_ID per FU.
REQ-010 SHALL have port cdb  output  cdb_t  registered broadcast (valid, preg, pkt, src index).

Function
REQ-011 SHALL transfer a result from FU i only in a cycle where fu_valid[i] and fu_ready[i] are both 1.
REQ-012 SHALL assert at most one fu_ready bit per cycle (one-hot or zero).
REQ-013 SHALL grant the first valid requester at or after rr_ptr, searching upward with wrap from NUM_FU-1 to 0.
REQ-014 SHALL update rr_ptr to (granted index + 1) mod NUM_FU on each transfer; unchanged when no transfer.
REQ-015 SHALL never stall the grant for downstream reasons: with any fu_valid set and flush low, exactly one fu_ready is 1.
REQ-016 SHALL present a transferred result on cdb exactly one cycle after the transfer (cdb.valid=1, preg, pkt, src=granted index).
REQ-017 SHALL drive cdb.valid=0 in the cycle after any cycle with no transfer; other cdb fields hold their previous value.
REQ-018 SHALL guarantee that a requester holding fu_valid continuously is granted within NUM_FU cycles.
REQ-019 SHALL ignore fu_preg and fu_pkt of any requester not granted in that cycle.
REQ-020 SHALL force fu_ready to all zeros while flush=1, drive cdb.valid=0 on the next cycle, and reset rr_ptr to 0.
REQ-021 SHALL give flush priority over a simultaneous request: no transfer occurs in a flush cycle.
REQ-022 SHALL broadcast preg=0 results like any other result; x0 filtering is the regfile's responsibility.

Reset
REQ-023 SHALL on rst=1 clear cdb to all zeros, clear rr_ptr to 0, and drive fu_ready to zeros in that cycle.
REQ-024 SHALL give rst priority over flush and over any request, including a reset asserted mid-burst.

Configuration
REQ-025 SHALL, when CDB_STALL_CNT_EN is defined, add output port stall_cnt (32 bits), counting cycles with two or more fu_valid bits set and flush=0.
REQ-026 SHALL saturate stall_cnt at 32'hFFFF_FFFF, clear it only on rst (not on flush), and leave it unchanged by arbitration.
REQ-027 SHALL omit stall_cnt and its logic entirely when CDB_STALL_CNT_EN is not defined, with arbitration behaviour unchanged.

Structure
REQ-028 SHALL place cdb_t in package rv32i_types: packed {valid, preg[7:0], physical_reg_packet pkt, src[2:0]}.
REQ-029 SHALL implement the grant search and pointer in one sub-module, rr_arbiter (parameter N; ports req, grant, advance; pointer held inside).
REQ-030 SHALL keep the result mux and cdb register in cdb_arbiter itself.

Verification
REQ-031 Check: reset, then fu_valid=3'b010, fu_preg[1]=8'h21, pkt={32'hDEAD_BEEF, ROB_ID 8'h05}. Required: fu_ready=3'b010; next cycle cdb={1, 8'h21, DEAD_BEEF/05, src 1}.
REQ-032 Check: fu_valid=3'b111 held 6 cycles from rr_ptr=0. Required: grant sequence 0,1,2,0,1,2; cdb.valid=1 for every cycle from cycle 1 to cycle 6.
REQ-033 Check: fu_valid=3'b101 with rr_ptr=1. Required: FU2 is granted first, then FU0; FU2 is not granted again before FU0.
REQ-034 Check: flush=1 with fu_valid=3'b111. Required: fu_ready=0; next cycle cdb.valid=0 and rr_ptr=0; first grant after flush goes to FU0.
REQ-035 Check: rst asserted in the cycle after a transfer. Required: next cycle cdb is all zeros and rr_ptr=0.
REQ-036 Check: with CDB_STALL_CNT_EN, 4 cycles of fu_valid=3'b011 then 2 cycles of 3'b001. Required: stall_cnt=4; stall_cnt unchanged by a subsequent flush.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus (CDB) writeback arbiter.
//   physical_reg_packet : a result value plus the ROB entry it belongs to
//   cdb_t               : one registered CDB broadcast {valid, preg, pkt, src}
// The CDB physical register field is fixed at 8 bits.
// This matches the free list's physical register index width.
package rv32i_types;

  localparam int CDB_PREG_W = 8;
  localparam int CDB_SRC_W  = 3;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  rob_id;
  } physical_reg_packet;

  typedef struct packed {
    logic                  valid;
    logic [CDB_PREG_W-1:0] preg;
    physical_reg_packet    pkt;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback bus between the functional units and the CDB arbiter.
//   flush    : pipeline flush after a branch mispredict (FU side -> arbiter)
//   fu_valid : per-FU writeback request
//   fu_ready : per-FU grant; at most one bit set, combinational
//   fu_preg  : destination physical register per FU
//   fu_pkt   : result value + ROB_ID per FU
//   cdb      : registered broadcast
// Modport master = functional-unit side.
// Modport slave  = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 3,
  parameter int PREG_W = 8
);
  import rv32i_types::*;

  logic                                flush;
  logic [NUM_FU-1:0]                   fu_valid;
  logic [NUM_FU-1:0]                   fu_ready;
  logic [NUM_FU-1:0][PREG_W-1:0]       fu_preg;
  physical_reg_packet [NUM_FU-1:0]     fu_pkt;
  cdb_t                                cdb;

  modport master (
    output flush, fu_valid, fu_preg, fu_pkt,
    input  fu_ready, cdb
  );

  modport slave (
    input  flush, fu_valid, fu_preg, fu_pkt,
    output fu_ready, cdb
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Round-robin grant search with an internal rotating pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   clear    : returns the pointer to 0 (used on pipeline flush)
//   req      : request vector
//   advance  : a grant was consumed this cycle
//              the pointer moves to the slot just past the winner
//   grant    : one-hot (or zero) grant, combinational
// The search starts at the pointer.
// It walks upward and wraps from N-1 back to 0.
// A continuously asserted request is therefore served within N cycles.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  int               idx;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    next_ptr = ptr_q;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % N);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (advance && found) begin
      ptr_d = next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one functional-unit result per cycle, round-robin.
// It broadcasts that result on a registered common data bus.
//   clk       : system clock
//   rst       : synchronous active-high reset
//               clears cdb and the pointer, forces fu_ready low
//   bus       : cdb_arbiter_if.slave
//               carries flush, fu_valid/fu_ready handshake, fu_preg, fu_pkt, cdb
//   stall_cnt : present only when CDB_STALL_CNT_EN is defined
//               saturating count of cycles with two or more requesters
//               and no flush
// Optional feature macro: CDB_STALL_CNT_EN.
// Precedence: rst beats flush, and flush beats any request.
// The grant itself never waits on anything downstream.
// preg 0 results are broadcast like any other result.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = 3,
  parameter int PREG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  cdb_arbiter_if.slave bus
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic [NUM_FU-1:0]   req;
  logic [NUM_FU-1:0]   grant;
  logic                xfer;
  logic [PREG_W-1:0]   preg_sel;
  physical_reg_packet  pkt_sel;
  logic [CDB_SRC_W-1:0] src_sel;
  cdb_t                cdb_q;
  cdb_t                cdb_d;

  // Masking the requests keeps the grant low during flush or reset.
  // No transfer happens, and the pointer cannot advance.
  assign req  = bus.fu_valid & {NUM_FU{~(bus.flush | rst)}};
  assign xfer = |grant;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.flush),
    .req     (req),
    .advance (xfer),
    .grant   (grant)
  );

  assign bus.fu_ready = grant;

  // One-hot select.
  // Non-granted FUs' preg/pkt never reach the bus.
  always_comb begin
    preg_sel = '0;
    pkt_sel  = '0;
    src_sel  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        preg_sel = bus.fu_preg[i];
        pkt_sel  = bus.fu_pkt[i];
        src_sel  = CDB_SRC_W'(i);
      end
    end
  end

  // Idle cycles drop valid but keep the last payload.
  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    if (xfer) begin
      cdb_d.valid = 1'b1;
      cdb_d.preg  = CDB_PREG_W'(preg_sel);
      cdb_d.pkt   = pkt_sel;
      cdb_d.src   = src_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q <= '0;
    end else begin
      cdb_q <= cdb_d;
    end
  end

  assign bus.cdb = cdb_q;

`ifdef CDB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Counts contention and saturates at the maximum.
  // A flush neither counts nor clears.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.flush && ($countones(bus.fu_valid) >= 2) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
